parity_checker: RTL
===================

# parity_checker

Serial receive-side companion to the team's 7-bit even-parity generator. It deserializes a frame of `DATA_W` data bits followed by one parity bit and recomputes parity over the data. It presents the data word with a one-cycle `frame_valid` pulse and a parity-error flag, and keeps a saturating count of bad frames. It sits at the receiving end of the serial parity link, between the bit-level input and downstream word consumers.

## Interface
- `DATA_W`, default 7: data bits per frame; frame length is `DATA_W`+1.
- `ODD_PARITY`, default 0: 0 = even parity, matching the generator (parity bit = XOR of data bits); 1 = odd parity.
- `CNT_W`, default 8: width of `err_count`.
- `clk` in 1: single clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high.
- `din` in 1: serial data bit.
- `din_valid` in 1: `din` is sampled only on edges where this is high.
- `sof` in 1: marks the first data bit of a frame; ignored unless `din_valid`=1.
- `err_clr` in 1: synchronous clear of `err_count`.
- `data_out` out `DATA_W`: last completed frame's data; first received bit is the MSB.
- `parity_out` out 1: received parity bit of the last completed frame.
- `frame_valid` out 1: one-cycle pulse when a frame completes.
- `parity_err` out 1: parity result of the last completed frame; held until the next `frame_valid`.
- `err_count` out `CNT_W`: number of frames with a parity error; saturates at all-ones.
- `busy` out 1: high while a frame is partially received (state RECV).

## Operation
- Frame order on the wire: d[DATA_W-1] first, down to d[0], then the parity bit.
- States:
  - IDLE.
  - RECV: bit counter `bcnt` (width clog2(DATA_W+1)+1), shift register, running XOR `acc`.
- IDLE:
  - `din_valid`&`sof`: load shift reg with `din`, `acc`=`din`, `bcnt`=1, go to RECV.
  - `din_valid` without `sof`: bit discarded, stay in IDLE.
- RECV, `din_valid`=0: hold all state, no output change.
- RECV, `din_valid`&`sof`: abort the current frame with no `frame_valid` and no count change. Restart as in IDLE, with this bit as the new first bit.
- RECV, `din_valid`&!`sof`, `bcnt`<`DATA_W`: shift `din` in at the LSB, `acc`^=`din`, `bcnt`++.
- RECV, `din_valid`&!`sof`, `bcnt`==`DATA_W` (parity bit): on the same edge, do all of the following, then go to IDLE:
  - register `data_out`←shift reg and `parity_out`←`din`;
  - set `parity_err` ← (`acc`^`din`^`ODD_PARITY`) != 0;
  - pulse `frame_valid`.
- `err_count`:
  - increments on each `frame_valid` with `parity_err`=1;
  - holds at 2^`CNT_W`−1 once reached.
- `err_clr` and a counted error on the same edge: the result is 1, so no error is lost. `err_clr` alone gives 0.
- Outputs not updated by a frame keep their previous value.

## Timing
- Reset: state IDLE and `bcnt`=0. All outputs are 0 at reset: `data_out`, `parity_out`, `frame_valid`, `parity_err`, `err_count`, `busy`.
- Reset mid-frame discards the partial frame; no `frame_valid`.
- Latency: `frame_valid`, `data_out`, `parity_out` and `parity_err` are valid in the cycle right after the edge that samples the parity bit.
- `frame_valid` is high for exactly one cycle.
- `err_count` reflects that frame in the same cycle as `frame_valid`.
- Back-to-back frames: `sof` on the cycle right after the parity bit is accepted, giving a minimum frame period of `DATA_W`+1 cycles.
- `busy` rises the cycle after the `sof` bit and falls together with the rise of `frame_valid`.
- Gaps (`din_valid`=0) anywhere in a frame stretch it but do not otherwise affect the result.

## Test plan
- Even parity, continuous valid, bits 1,0,1,1,0,0,1 then parity 0 -> `frame_valid` pulse, `data_out`=7'h59, `parity_out`=0, `parity_err`=0, `err_count`=0.
- Same data with parity 1 -> `parity_err`=1 and `err_count`=1. A following good frame clears `parity_err` and leaves `err_count`=1.
- Frame 7'h59/parity 0 with random `din_valid`=0 gaps of 1–5 cycles, plus valid non-`sof` bits sent while IDLE -> same result as the first scenario; exactly one `frame_valid`.
- `sof` re-asserted on the 4th bit, followed by a full good frame 7'h2A/parity 1 -> a single `frame_valid` with `data_out`=7'h2A, `parity_err`=0. Separately, `reset` after 3 bits -> no pulse and all outputs 0.
- 260 back-to-back bad frames -> `err_count` reaches 8'hFF and holds. Then `err_clr` on the edge of another bad frame -> `err_count`=1; `err_clr` alone -> 0.
- `ODD_PARITY`=1 with data 7'h00 and parity 1 -> `parity_err`=0; with parity 0 -> `parity_err`=1.

Source files
------------

// File: rtl/parity_checker.sv
// Serial frame receiver: deserializes DATA_W data bits plus one parity bit,
// checks parity, presents the word with a one-cycle pulse and counts bad frames.
module parity_checker #(
  parameter int DATA_W     = 7,
  parameter int ODD_PARITY = 0,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              din,
  input  logic              din_valid,
  input  logic              sof,
  input  logic              err_clr,
  output logic [DATA_W-1:0] data_out,
  output logic              parity_out,
  output logic              frame_valid,
  output logic              parity_err,
  output logic [CNT_W-1:0]  err_count,
  output logic              busy
);

  localparam int BCNT_W = $clog2(DATA_W + 1) + 1;
  localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(DATA_W);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic              PAR_SEED = (ODD_PARITY != 0);

  typedef enum logic {
    IDLE,
    RECV
  } state_t;

  state_t              state_reg, state_next;
  logic [BCNT_W-1:0]   bcnt_reg, bcnt_next;
  logic [DATA_W-1:0]   shift_reg, shift_next;
  logic [DATA_W-1:0]   shift_in;
  logic                acc_reg, acc_next;
  logic                frame_done;
  logic                frame_bad;
  logic [CNT_W-1:0]    count_next;

  // New bit enters at the LSB so the first received bit ends up as the MSB.
  assign shift_in[0] = din;
  generate
    for (genvar gi = 1; gi < DATA_W; gi++) begin : g_shift
      assign shift_in[gi] = shift_reg[gi-1];
    end
  endgenerate

  // Parity is checked against the incoming parity bit on the closing edge.
  assign frame_bad = acc_reg ^ din ^ PAR_SEED;

  always_comb begin
    state_next = state_reg;
    bcnt_next  = bcnt_reg;
    shift_next = shift_reg;
    acc_next   = acc_reg;
    frame_done = 1'b0;
    case (state_reg)
      IDLE: begin
        if (din_valid && sof) begin
          state_next    = RECV;
          bcnt_next     = BCNT_W'(1);
          shift_next    = '0;
          shift_next[0] = din;
          acc_next      = din;
        end
      end
      RECV: begin
        if (din_valid) begin
          if (sof) begin
            // A fresh start-of-frame aborts the partial frame silently.
            state_next    = RECV;
            bcnt_next     = BCNT_W'(1);
            shift_next    = '0;
            shift_next[0] = din;
            acc_next      = din;
          end else if (bcnt_reg == LAST_BIT) begin
            frame_done = 1'b1;
            state_next = IDLE;
            bcnt_next  = '0;
          end else begin
            shift_next = shift_in;
            acc_next   = acc_reg ^ din;
            bcnt_next  = bcnt_reg + BCNT_W'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
        bcnt_next  = '0;
      end
    endcase
  end

  // A counted error wins over a simultaneous clear so it is never lost.
  always_comb begin
    count_next = err_count;
    if (frame_done && frame_bad) begin
      if (err_clr)
        count_next = CNT_W'(1);
      else if (err_count != CNT_MAX)
        count_next = err_count + CNT_W'(1);
    end else if (err_clr) begin
      count_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      bcnt_reg    <= '0;
      shift_reg   <= '0;
      acc_reg     <= 1'b0;
      data_out    <= '0;
      parity_out  <= 1'b0;
      frame_valid <= 1'b0;
      parity_err  <= 1'b0;
      err_count   <= '0;
    end else begin
      state_reg   <= state_next;
      bcnt_reg    <= bcnt_next;
      shift_reg   <= shift_next;
      acc_reg     <= acc_next;
      frame_valid <= frame_done;
      err_count   <= count_next;
      if (frame_done) begin
        data_out   <= shift_reg;
        parity_out <= din;
        parity_err <= frame_bad;
      end
    end
  end

  assign busy = (state_reg == RECV);

endmodule
